// File: rtl/range_scheduler.sv
// range_scheduler: round-robin arbiter that shares one range-finder datapath
// between NUM_REQ sample-burst requesters. It streams the granted burst through
// go/data/finish, waits RESULT_LAT cycles, and returns the captured range and
// error tagged with the requester id.
module range_scheduler #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned RESULT_LAT = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]           req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               rf_go,
    output logic                               rf_finish,
    output logic [WIDTH-1:0]                   rf_data,
    input  logic [WIDTH-1:0]                   rf_range,
    input  logic                               rf_error,
    output logic                               res_valid,
    output logic [WIDTH-1:0]                   res_range,
    output logic [$clog2(NUM_REQ)-1:0]         res_id,
    output logic                               res_error,
    output logic                               res_trunc,
    output logic                               busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(MAX_LEN + 1);
    localparam int unsigned LW  = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = (RESULT_LAT > 0) ? LW'(RESULT_LAT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_STREAM,
        S_FINISH,
        S_WAIT,
        S_REPORT,
        S_DRAIN
    } state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_rr;
    logic [IDW-1:0]       r_winner;
    logic [NUM_REQ-1:0]   r_grant;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_hold;
    logic                 r_trunc;
    logic [LW-1:0]        r_lat;
    logic [WIDTH-1:0]     r_res_range;
    logic [IDW-1:0]       r_res_id;
    logic                 r_res_error;
    logic                 r_res_trunc;

    logic [WIDTH-1:0]     w_sample;
    logic                 w_win_valid;
    logic                 w_win_last;
    logic                 w_hit_hi;
    logic                 w_hit_lo;
    logic [IDW-1:0]       w_pick_hi;
    logic [IDW-1:0]       w_pick_lo;
    logic [IDW-1:0]       w_pick;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [IDW-1:0]       w_rr_next;
    logic                 w_capture;

    // Select the granted requester's sample; valid/last come straight from the grant mask.
    always_comb begin
        w_sample = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == r_winner) begin
                w_sample = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_win_valid = |(req_valid & r_grant);
    assign w_win_last  = |(req_last & r_grant);

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall (wrap).
    always_comb begin
        w_hit_hi  = 1'b0;
        w_hit_lo  = 1'b0;
        w_pick_hi = '0;
        w_pick_lo = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_hit_hi && (IDW'(i) >= r_rr)) begin
                w_hit_hi  = 1'b1;
                w_pick_hi = IDW'(i);
            end
            if (req_valid[i] && !w_hit_lo) begin
                w_hit_lo  = 1'b1;
                w_pick_lo = IDW'(i);
            end
        end
        w_pick    = w_hit_hi ? w_pick_hi : w_pick_lo;
        w_pick_oh = NUM_REQ'(1) << w_pick;
    end

    assign w_rr_next = (r_winner == IDW'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

    // Datapath result is sampled at the edge closing the cycle RESULT_LAT cycles after FINISH.
    assign w_capture = (RESULT_LAT == 0) ? (r_state == S_FINISH)
                                         : ((r_state == S_WAIT) && (r_lat == LAT_LAST));

    // Main scheduler FSM with grant, burst bookkeeping and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_winner    <= '0;
            r_grant     <= '0;
            r_count     <= '0;
            r_hold      <= '0;
            r_trunc     <= 1'b0;
            r_lat       <= '0;
            r_res_range <= '0;
            r_res_id    <= '0;
            r_res_error <= 1'b0;
            r_res_trunc <= 1'b0;
        end else begin
            if (w_capture) begin
                r_res_range <= rf_range;
                r_res_error <= rf_error;
                r_res_id    <= r_winner;
                r_res_trunc <= r_trunc;
            end
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_winner <= w_pick;
                        r_grant  <= w_pick_oh;
                        r_trunc  <= 1'b0;
                        r_count  <= '0;
                        r_state  <= S_GO;
                    end
                end
                S_GO: begin
                    r_hold  <= w_sample;
                    r_count <= CW'(1);
                    if (w_win_valid && w_win_last) begin
                        r_state <= S_FINISH;
                    end else if (MAX_LEN == 1) begin
                        r_trunc <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_win_valid) begin
                        r_hold  <= w_sample;
                        r_count <= r_count + 1'b1;
                        if (w_win_last) begin
                            r_state <= S_FINISH;
                        end else if ((r_count + 1'b1) == CW'(MAX_LEN)) begin
                            r_trunc <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_lat   <= '0;
                    r_state <= (RESULT_LAT == 0) ? S_REPORT : S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state <= S_REPORT;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_REPORT: begin
                    r_rr <= w_rr_next;
                    // A truncated burst never saw its last; keep the grant to swallow the tail.
                    if (r_trunc) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (w_win_valid && w_win_last) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-state strobes and data steering toward requesters and datapath.
    always_comb begin
        req_ready = '0;
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        rf_data   = '0;
        case (r_state)
            S_GO: begin
                req_ready = r_grant;
                rf_go     = 1'b1;
                rf_data   = w_sample;
            end
            S_STREAM: begin
                req_ready = r_grant;
                rf_data   = w_win_valid ? w_sample : r_hold;
            end
            S_FINISH: begin
                rf_finish = 1'b1;
                rf_data   = r_hold;
            end
            S_DRAIN: begin
                req_ready = r_grant;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign res_valid = (r_state == S_REPORT);
    assign res_range = r_res_range;
    assign res_id    = r_res_id;
    assign res_error = r_res_error;
    assign res_trunc = r_res_trunc;
    assign busy      = (r_state != S_IDLE);

endmodule
